// File: rtl/dma64_pkg.sv
// Shared DMA ctrl/chnl definitions for the 64-bit responder and the accelerator wrappers.
package dma64_pkg;

    localparam int unsigned BEAT_W      = 64;
    localparam logic [2:0]  DMA_SIZE_64 = 3'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_STREAM = 2'd1,
        WR_STREAM = 2'd2
    } dma_state_e;

endpackage

// File: rtl/dma64_word_ram.sv
// 64-bit word memory: one write port, an async read port for streaming
// and a registered read port for the backdoor (read-before-write).
module dma64_word_ram
    import dma64_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [BEAT_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [BEAT_W-1:0] rdata_o,
    input  logic              bd_re_i,
    input  logic [ADDR_W-1:0] bd_addr_i,
    output logic [BEAT_W-1:0] bd_rdata_o
);

    logic [BEAT_W-1:0] mem_q [MEM_WORDS];
    logic [BEAT_W-1:0] bd_rdata_q;

    // Contents survive reset on purpose: preloaded data must outlive a DMA abort.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bd_rdata_q <= '0;
        end else if (bd_re_i) begin
            bd_rdata_q <= mem_q[bd_addr_i];
        end
    end

    assign rdata_o    = mem_q[raddr_i];
    assign bd_rdata_o = bd_rdata_q;

endmodule

// File: rtl/dma64_mem_responder.sv
// Target-side DMA responder: streams read beats from and absorbs write beats
// into an internal word memory, with a backdoor for preload and readback.
module dma64_mem_responder
    import dma64_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dma_read_ctrl_valid,
    input  logic [31:0]       dma_read_ctrl_data_index,
    input  logic [31:0]       dma_read_ctrl_data_length,
    input  logic [2:0]        dma_read_ctrl_data_size,
    output logic              dma_read_ctrl_ready,
    output logic              dma_read_chnl_valid,
    output logic [63:0]       dma_read_chnl_data,
    input  logic              dma_read_chnl_ready,
    input  logic              dma_write_ctrl_valid,
    input  logic [31:0]       dma_write_ctrl_data_index,
    input  logic [31:0]       dma_write_ctrl_data_length,
    input  logic [2:0]        dma_write_ctrl_data_size,
    output logic              dma_write_ctrl_ready,
    input  logic              dma_write_chnl_valid,
    input  logic [63:0]       dma_write_chnl_data,
    output logic              dma_write_chnl_ready,
    input  logic              bd_en,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [63:0]       bd_wdata,
    output logic [63:0]       bd_rdata,
    output logic              bd_drop,
    output logic              busy,
    output logic              err_size,
    output logic [15:0]       txn_count
);

    dma_state_e        state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [31:0]       left_q;
    logic              rd_valid_q;
    logic [63:0]       rd_data_q;
    logic              wr_ready_q;
    logic              err_size_q;
    logic [15:0]       txn_q;
    logic              bd_drop_q;

    logic              ctrl_idle;
    logic              rd_hs;
    logic              wr_hs;
    logic              rd_beat;
    logic              wr_beat;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_len;
    logic [2:0]        acc_size;
    logic              bd_wr_req;
    logic              bd_wr_ok;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [63:0]       ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [63:0]       ram_rdata;
    logic              idx_hi_unused;

    assign ctrl_idle = (state_q == IDLE) && !rst;
    assign rd_hs     = ctrl_idle && dma_read_ctrl_valid;
    // Read wins a tie; the write request stays pending without a handshake.
    assign wr_hs     = ctrl_idle && dma_write_ctrl_valid && !dma_read_ctrl_valid;
    assign rd_beat   = (state_q == RD_STREAM) && rd_valid_q && dma_read_chnl_ready;
    assign wr_beat   = (state_q == WR_STREAM) && wr_ready_q && dma_write_chnl_valid;

    assign acc_idx  = dma_read_ctrl_valid ? dma_read_ctrl_data_index[ADDR_W-1:0]
                                          : dma_write_ctrl_data_index[ADDR_W-1:0];
    assign acc_len  = dma_read_ctrl_valid ? dma_read_ctrl_data_length : dma_write_ctrl_data_length;
    assign acc_size = dma_read_ctrl_valid ? dma_read_ctrl_data_size : dma_write_ctrl_data_size;

    assign idx_hi_unused = ^{dma_read_ctrl_data_index[31:ADDR_W], dma_write_ctrl_data_index[31:ADDR_W]};

    assign bd_wr_req = bd_en && bd_we;
    assign bd_wr_ok  = bd_wr_req && ctrl_idle && !dma_read_ctrl_valid && !dma_write_ctrl_valid;

    assign ram_we    = !rst && (wr_beat || bd_wr_ok);
    assign ram_waddr = (state_q == WR_STREAM) ? ptr_q : bd_addr;
    assign ram_wdata = (state_q == WR_STREAM) ? dma_write_chnl_data : bd_wdata;
    // Prefetch address: the request index on entry, the following word while streaming.
    assign ram_raddr = (state_q == RD_STREAM) ? ptr_q + ADDR_W'(1) : acc_idx;

    dma64_word_ram #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .we_i       (ram_we),
        .waddr_i    (ram_waddr),
        .wdata_i    (ram_wdata),
        .raddr_i    (ram_raddr),
        .rdata_o    (ram_rdata),
        .bd_re_i    (bd_en),
        .bd_addr_i  (bd_addr),
        .bd_rdata_o (bd_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            left_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            wr_ready_q <= 1'b0;
            err_size_q <= 1'b0;
            txn_q      <= '0;
            bd_drop_q  <= 1'b0;
        end else begin
            bd_drop_q <= bd_wr_req && !bd_wr_ok;
            case (state_q)
                IDLE: begin
                    if (rd_hs || wr_hs) begin
                        if (acc_size != DMA_SIZE_64) begin
                            err_size_q <= 1'b1;
                        end
                        ptr_q  <= acc_idx;
                        left_q <= acc_len;
                        if (acc_len == 32'd0) begin
                            txn_q <= txn_q + 16'd1;
                        end else if (rd_hs) begin
                            state_q    <= RD_STREAM;
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= ram_rdata;
                        end else begin
                            state_q    <= WR_STREAM;
                            wr_ready_q <= 1'b1;
                        end
                    end
                end
                RD_STREAM: begin
                    if (rd_beat) begin
                        ptr_q  <= ptr_q + ADDR_W'(1);
                        left_q <= left_q - 32'd1;
                        if (left_q == 32'd1) begin
                            rd_valid_q <= 1'b0;
                            txn_q      <= txn_q + 16'd1;
                            state_q    <= IDLE;
                        end else begin
                            rd_data_q <= ram_rdata;
                        end
                    end
                end
                WR_STREAM: begin
                    if (wr_beat) begin
                        ptr_q  <= ptr_q + ADDR_W'(1);
                        left_q <= left_q - 32'd1;
                        if (left_q == 32'd1) begin
                            wr_ready_q <= 1'b0;
                            txn_q      <= txn_q + 16'd1;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    rd_valid_q <= 1'b0;
                    wr_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign dma_read_ctrl_ready  = ctrl_idle;
    assign dma_write_ctrl_ready = ctrl_idle && !dma_read_ctrl_valid;
    assign dma_read_chnl_valid  = rd_valid_q;
    assign dma_read_chnl_data   = rd_data_q;
    assign dma_write_chnl_ready = wr_ready_q;
    assign bd_drop              = bd_drop_q;
    assign busy                 = (state_q != IDLE);
    assign err_size             = err_size_q;
    assign txn_count            = txn_q;

endmodule

// File: tb/tb_dma64_mem_responder.sv
// Directed and randomized bench for dma64_mem_responder against a word-array reference model.
module tb_dma64_mem_responder;

    localparam int unsigned MEM = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_read_ctrl_valid;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic        dma_read_ctrl_ready;
    logic        dma_read_chnl_valid;
    logic [63:0] dma_read_chnl_data;
    logic        dma_read_chnl_ready;
    logic        dma_write_ctrl_valid;
    logic [31:0] dma_write_ctrl_data_index;
    logic [31:0] dma_write_ctrl_data_length;
    logic [2:0]  dma_write_ctrl_data_size;
    logic        dma_write_ctrl_ready;
    logic        dma_write_chnl_valid;
    logic [63:0] dma_write_chnl_data;
    logic        dma_write_chnl_ready;
    logic        bd_en;
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [63:0] bd_wdata;
    logic [63:0] bd_rdata;
    logic        bd_drop;
    logic        busy;
    logic        err_size;
    logic [15:0] txn_count;

    logic [63:0] model [MEM];
    logic [15:0] exp_txn;
    int unsigned checks = 0;
    int unsigned errors = 0;

    dma64_mem_responder #(
        .MEM_WORDS (1024),
        .ADDR_W    (10)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .dma_read_ctrl_valid        (dma_read_ctrl_valid),
        .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
        .dma_read_ctrl_ready        (dma_read_ctrl_ready),
        .dma_read_chnl_valid        (dma_read_chnl_valid),
        .dma_read_chnl_data         (dma_read_chnl_data),
        .dma_read_chnl_ready        (dma_read_chnl_ready),
        .dma_write_ctrl_valid       (dma_write_ctrl_valid),
        .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
        .dma_write_ctrl_ready       (dma_write_ctrl_ready),
        .dma_write_chnl_valid       (dma_write_chnl_valid),
        .dma_write_chnl_data        (dma_write_chnl_data),
        .dma_write_chnl_ready       (dma_write_chnl_ready),
        .bd_en                      (bd_en),
        .bd_we                      (bd_we),
        .bd_addr                    (bd_addr),
        .bd_wdata                   (bd_wdata),
        .bd_rdata                   (bd_rdata),
        .bd_drop                    (bd_drop),
        .busy                       (busy),
        .err_size                   (err_size),
        .txn_count                  (txn_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input int unsigned a, input logic [63:0] d);
        bd_en = 1'b1; bd_we = 1'b1; bd_addr = a[9:0]; bd_wdata = d;
        @(negedge clk);
        bd_en = 1'b0; bd_we = 1'b0;
        model[a % MEM] = d;
    endtask

    task automatic bd_check(input int unsigned a, input string tag);
        bd_en = 1'b1; bd_we = 1'b0; bd_addr = a[9:0];
        @(negedge clk);
        bd_en = 1'b0;
        chk(tag, bd_rdata, model[a % MEM]);
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0,1,..., 2: random ready
    task automatic do_read(input int unsigned idx, input int unsigned len,
                           input int unsigned mode, input bit poke);
        int unsigned got;
        int unsigned cyc;
        int unsigned pa;
        bit rdy;
        got = 0; cyc = 0; pa = (idx + 1) % MEM;
        dma_read_ctrl_valid = 1'b1;
        dma_read_ctrl_data_index = idx;
        dma_read_ctrl_data_length = len;
        dma_read_ctrl_data_size = 3'd3;
        chk("rd_ctrl_ready_idle", dma_read_ctrl_ready, 64'd1);
        @(negedge clk);
        dma_read_ctrl_valid = 1'b0;
        chk("rd_busy", busy, 64'd1);
        chk("rd_ctrl_ready_stream", dma_read_ctrl_ready, 64'd0);
        chk("wr_ctrl_ready_stream", dma_write_ctrl_ready, 64'd0);
        while (got < len && cyc < 4 * len + 20) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            if (poke && cyc == 0) begin
                rdy = 1'b0;
                bd_en = 1'b1; bd_we = 1'b1; bd_addr = pa[9:0]; bd_wdata = ~model[pa];
            end
            dma_read_chnl_ready = rdy;
            chk("rd_valid", dma_read_chnl_valid, 64'd1);
            chk("rd_data", dma_read_chnl_data, model[(idx + got) % MEM]);
            if (rdy && dma_read_chnl_valid) got++;
            @(negedge clk);
            cyc++;
            if (poke && cyc == 1) begin
                chk("bd_drop_pulse", bd_drop, 64'd1);
                bd_en = 1'b0; bd_we = 1'b0;
            end
        end
        dma_read_chnl_ready = 1'b0;
        chk("rd_beats", 64'(got), 64'(len));
        exp_txn++;
        chk("rd_valid_done", dma_read_chnl_valid, 64'd0);
        chk("rd_busy_done", busy, 64'd0);
        chk("rd_txn", txn_count, exp_txn);
        if (poke) chk("bd_drop_clear", bd_drop, 64'd0);
    endtask

    task automatic do_write(input int unsigned idx, input int unsigned len,
                            input bit rnd, input bit extra);
        int unsigned sent;
        int unsigned cyc;
        bit v;
        logic [63:0] d;
        sent = 0; cyc = 0;
        dma_write_ctrl_valid = 1'b1;
        dma_write_ctrl_data_index = idx;
        dma_write_ctrl_data_length = len;
        dma_write_ctrl_data_size = 3'd3;
        while (!dma_write_ctrl_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("wr_ctrl_ready", dma_write_ctrl_ready, 64'd1);
        @(negedge clk);
        dma_write_ctrl_valid = 1'b0;
        chk("wr_chnl_ready_first", dma_write_chnl_ready, 64'd1);
        cyc = 0;
        while (sent < len && cyc < 4 * len + 20) begin
            d = rnd ? {$urandom, $urandom} : 64'(64'hA0 + sent);
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            dma_write_chnl_valid = v;
            dma_write_chnl_data = d;
            if (v && dma_write_chnl_ready) begin
                model[(idx + sent) % MEM] = d;
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        dma_write_chnl_valid = 1'b0;
        chk("wr_beats", 64'(sent), 64'(len));
        exp_txn++;
        chk("wr_chnl_ready_done", dma_write_chnl_ready, 64'd0);
        chk("wr_busy_done", busy, 64'd0);
        chk("wr_txn", txn_count, exp_txn);
        if (extra) begin
            dma_write_chnl_valid = 1'b1;
            dma_write_chnl_data = 64'hDEAD_BEEF_0BAD_F00D;
            @(negedge clk);
            chk("wr_extra_not_ready", dma_write_chnl_ready, 64'd0);
            dma_write_chnl_valid = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] old;
        int unsigned ri;
        int unsigned rl;
        rst = 1'b1;
        dma_read_ctrl_valid = 1'b0; dma_read_ctrl_data_index = '0;
        dma_read_ctrl_data_length = '0; dma_read_ctrl_data_size = 3'd3;
        dma_read_chnl_ready = 1'b0;
        dma_write_ctrl_valid = 1'b0; dma_write_ctrl_data_index = '0;
        dma_write_ctrl_data_length = '0; dma_write_ctrl_data_size = 3'd3;
        dma_write_chnl_valid = 1'b0; dma_write_chnl_data = '0;
        bd_en = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
        exp_txn = '0;
        repeat (2) @(negedge clk);

        chk("rst_rd_ctrl_ready", dma_read_ctrl_ready, 64'd0);
        chk("rst_wr_ctrl_ready", dma_write_ctrl_ready, 64'd0);
        chk("rst_rd_valid", dma_read_chnl_valid, 64'd0);
        chk("rst_rd_data", dma_read_chnl_data, 64'd0);
        chk("rst_wr_chnl_ready", dma_write_chnl_ready, 64'd0);
        chk("rst_bd_rdata", bd_rdata, 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_err", err_size, 64'd0);
        chk("rst_txn", txn_count, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rd_ctrl_ready", dma_read_ctrl_ready, 64'd1);
        chk("idle_wr_ctrl_ready", dma_write_ctrl_ready, 64'd1);

        // Preload: random everywhere, then the 0x1000+i ramp at 0..27
        for (int unsigned i = 0; i < MEM; i++) bd_write(i, {$urandom, $urandom});
        for (int unsigned i = 0; i < 28; i++) bd_write(i, 64'(64'h1000 + i));

        // Backdoor read-before-write on the same address
        old = model[200];
        bd_en = 1'b1; bd_we = 1'b1; bd_addr = 10'd200; bd_wdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        bd_en = 1'b0; bd_we = 1'b0;
        chk("bd_read_before_write", bd_rdata, old);
        model[200] = 64'h1234_5678_9ABC_DEF0;
        bd_check(200, "bd_after_write");

        do_read(0, 28, 0, 1'b0);
        do_read(1022, 4, 1, 1'b0);

        do_write(5, 15, 1'b0, 1'b1);
        for (int unsigned i = 5; i <= 20; i++) bd_check(i, "wr_readback");

        // Simultaneous read and write requests: read first, write afterwards
        dma_write_ctrl_valid = 1'b1;
        dma_write_ctrl_data_index = 32'd300;
        dma_write_ctrl_data_length = 32'd6;
        dma_write_ctrl_data_size = 3'd3;
        dma_read_ctrl_valid = 1'b1;
        #1;
        chk("tie_rd_ready", dma_read_ctrl_ready, 64'd1);
        chk("tie_wr_ready", dma_write_ctrl_ready, 64'd0);
        do_read(310, 5, 2, 1'b0);
        do_write(300, 6, 1'b1, 1'b0);
        for (int unsigned i = 300; i < 306; i++) bd_check(i, "tie_wr_readback");

        // Size 2, length 0: error flag, no channel activity, transaction counted
        dma_read_ctrl_valid = 1'b1;
        dma_read_ctrl_data_index = 32'hFFFF_F123;
        dma_read_ctrl_data_length = 32'd0;
        dma_read_ctrl_data_size = 3'd2;
        @(negedge clk);
        dma_read_ctrl_valid = 1'b0;
        dma_read_ctrl_data_size = 3'd3;
        exp_txn++;
        chk("zl_err", err_size, 64'd1);
        chk("zl_busy", busy, 64'd0);
        chk("zl_rd_valid", dma_read_chnl_valid, 64'd0);
        chk("zl_txn", txn_count, exp_txn);
        @(negedge clk);
        chk("zl_rd_valid_later", dma_read_chnl_valid, 64'd0);

        // Backdoor write during a read stream is dropped; high index bits ignored
        do_read(32'h0001_0000 + 40, 4, 0, 1'b1);
        chk("err_sticky", err_size, 64'd1);
        bd_check(41, "bd_drop_mem_unchanged");

        // Randomized transactions
        for (int unsigned t = 0; t < 10; t++) begin
            ri = $urandom_range(0, MEM - 1);
            rl = $urandom_range(1, 24);
            if ($urandom_range(0, 1) == 1) do_read(ri, rl, 2, 1'b0);
            else do_write(ri, rl, 1'b1, 1'b0);
        end

        // Reset after three beats of a ten-beat write
        dma_write_ctrl_valid = 1'b1;
        dma_write_ctrl_data_index = 32'd100;
        dma_write_ctrl_data_length = 32'd10;
        dma_write_ctrl_data_size = 3'd3;
        @(negedge clk);
        dma_write_ctrl_valid = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            chk("rw_chnl_ready", dma_write_chnl_ready, 64'd1);
            dma_write_chnl_valid = 1'b1;
            dma_write_chnl_data = {$urandom, $urandom};
            if (dma_write_chnl_ready) model[100 + k] = dma_write_chnl_data;
            @(negedge clk);
        end
        dma_write_chnl_valid = 1'b1;
        dma_write_chnl_data = 64'hBAAD_BAAD_BAAD_BAAD;
        rst = 1'b1;
        @(negedge clk);
        exp_txn = '0;
        chk("rr_rd_ctrl_ready", dma_read_ctrl_ready, 64'd0);
        chk("rr_wr_ctrl_ready", dma_write_ctrl_ready, 64'd0);
        chk("rr_rd_valid", dma_read_chnl_valid, 64'd0);
        chk("rr_rd_data", dma_read_chnl_data, 64'd0);
        chk("rr_wr_chnl_ready", dma_write_chnl_ready, 64'd0);
        chk("rr_bd_rdata", bd_rdata, 64'd0);
        chk("rr_bd_drop", bd_drop, 64'd0);
        chk("rr_busy", busy, 64'd0);
        chk("rr_err", err_size, 64'd0);
        chk("rr_txn", txn_count, 64'd0);
        rst = 1'b0;
        dma_write_chnl_valid = 1'b0;
        @(negedge clk);
        chk("rr_idle_ready", dma_read_ctrl_ready, 64'd1);
        for (int unsigned i = 100; i < 110; i++) bd_check(i, "rr_mem");

        // Full memory sweep against the model
        for (int unsigned i = 0; i < MEM; i++) bd_check(i, "final_mem");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
